// File: rtl/matvec_pkg.sv
// rtl/matvec_pkg.sv - shared Q4.12 constants, enums and saturation helper
package matvec_pkg;

  localparam int Q_FRAC = 12;
  localparam int ONE_Q  = 1 << Q_FRAC;

  typedef enum logic [1:0] {
    ACT_IDENTITY     = 2'b00,
    ACT_HSIGMOID     = 2'b01,
    ACT_HTANH        = 2'b10,
    ACT_IDENTITY_ALT = 2'b11
  } act_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COLLECT = 2'b01,
    ST_READY   = 2'b10
  } gab_state_e;

  // Clamps v to the signed range of a width-bit word; caller truncates the result.
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                      input int unsigned      width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/act_pwl.sv
// rtl/act_pwl.sv - combinational piecewise-linear activation (identity, hard sigmoid, hard tanh)
module act_pwl
  import matvec_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic signed [DATA_WIDTH+1:0] x,
  input  act_sel_e                     act_sel,
  output logic signed [DATA_WIDTH-1:0] y
);

  localparam int W = DATA_WIDTH + 4;
  localparam logic signed [W-1:0] ONE_W  = W'(ONE_Q);
  localparam logic signed [W-1:0] HALF_W = W'(ONE_Q / 2);

  logic signed [W-1:0] xw;
  logic signed [W-1:0] sig;
  logic signed [W-1:0] r;

  always_comb begin
    xw  = W'(x);
    sig = (xw >>> 2) + HALF_W;
    r   = xw;
    case (act_sel)
      ACT_HSIGMOID: r = (sig < 0) ? '0 : ((sig > ONE_W) ? ONE_W : sig);
      ACT_HTANH:    r = (xw < -ONE_W) ? -ONE_W : ((xw > ONE_W) ? ONE_W : xw);
      default:      r = xw;
    endcase
    y = DATA_WIDTH'(sat_to_width(64'(r), DATA_WIDTH));
  end

endmodule

// File: rtl/gate_activation_buffer.sv
// rtl/gate_activation_buffer.sv - collects activated matvec rows and serves BANDWIDTH-wide reads
// Optional per-row bias add before activation: GAB_BIAS_ADD_EN.
module gate_activation_buffer
  import matvec_pkg::*;
#(
  parameter int MAX_ROWS   = 64,
  parameter int BANDWIDTH  = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [$clog2(MAX_ROWS):0]            num_rows,
  input  logic [1:0]                           act_sel,
  input  logic signed [DATA_WIDTH-1:0]         result_in,
  input  logic                                 result_valid,
`ifdef GAB_BIAS_ADD_EN
  input  logic signed [DATA_WIDTH-1:0]         bias_in,
`endif
  input  logic                                 out_read_en,
  input  logic [$clog2(MAX_ROWS)-1:0]          out_base_addr,
  output logic [BANDWIDTH-1:0][DATA_WIDTH-1:0] out_data,
  output logic                                 out_valid,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 overrun
);

  localparam int AW = $clog2(MAX_ROWS);
  localparam int RW = AW + 1;
  localparam int XW = DATA_WIDTH + 2;
  localparam int IW = RW + $clog2(BANDWIDTH + 1);

  gab_state_e                          state;
  gab_state_e                          next_state;
  logic [RW-1:0]                       row;
  logic [RW-1:0]                       target;
  act_sel_e                            act_q;
  logic                                s1_vld;
  logic signed [DATA_WIDTH-1:0]        s1_val;
  logic signed [DATA_WIDTH-1:0]        buffer [MAX_ROWS];
  logic signed [XW-1:0]                x_in;
  logic signed [DATA_WIDTH-1:0]        act_y;
  logic [BANDWIDTH-1:0][DATA_WIDTH-1:0] rd_data;
  logic                                in_collect;
  logic                                beat;
  logic                                write_row;
  logic                                last_write;

`ifdef GAB_BIAS_ADD_EN
  logic signed [DATA_WIDTH:0]   x_sum;
  logic signed [DATA_WIDTH-1:0] x_sat;

  always_comb begin
    x_sum = (DATA_WIDTH + 1)'(result_in) + (DATA_WIDTH + 1)'(bias_in);
    x_sat = DATA_WIDTH'(sat_to_width(64'(x_sum), DATA_WIDTH));
    x_in  = XW'(x_sat);
  end
`else
  assign x_in = XW'(result_in);
`endif

  act_pwl #(.DATA_WIDTH(DATA_WIDTH)) u_act (
    .x      (x_in),
    .act_sel(act_q),
    .y      (act_y)
  );

  // A start in the same cycle wins over both pipeline stages.
  assign in_collect = (state == ST_COLLECT);
  assign beat       = result_valid && in_collect && !start;
  assign write_row  = s1_vld && in_collect && !start;
  assign last_write = write_row && ((row + RW'(1)) == target);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (start)                                        next_state = ST_COLLECT;
    else if (in_collect && (target == '0 || last_write)) next_state = ST_READY;
  end

  always_comb begin
    busy = in_collect;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row     <= '0;
      target  <= '0;
      act_q   <= ACT_IDENTITY;
      s1_vld  <= 1'b0;
      s1_val  <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done   <= in_collect && (next_state == ST_READY);
      s1_vld <= beat;
      if (beat) s1_val <= act_y;
      if (start) begin
        row     <= '0;
        target  <= (num_rows > RW'(MAX_ROWS)) ? RW'(MAX_ROWS) : num_rows;
        act_q   <= act_sel_e'(act_sel);
        overrun <= 1'b0;
      end else begin
        if (write_row) row <= row + RW'(1);
        if (result_valid && !in_collect) overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (write_row) buffer[row[AW-1:0]] <= s1_val;
  end

  // Rows at or beyond the collected count read as zero, whatever the array still holds.
  for (genvar k = 0; k < BANDWIDTH; k++) begin : g_rd
    logic [IW-1:0] idx;
    logic [AW-1:0] addr;
    assign idx        = IW'(out_base_addr) + IW'(k);
    assign addr       = out_base_addr + AW'(k);
    assign rd_data[k] = (idx < IW'(row)) ? buffer[addr] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= out_read_en && (state == ST_READY);
      if (out_read_en && (state == ST_READY)) out_data <= rd_data;
    end
  end

endmodule

// File: doc/gate_activation_buffer.md
GATE_ACTIVATION_BUFFER -- requirements
Module: gate_activation_buffer

Interface
REQ-001 Parameter MAX_ROWS, default 64, SHALL set the maximum number of result rows buffered.
REQ-002 Parameter BANDWIDTH, default 4, SHALL set the number of words returned per read.
REQ-003 Parameter DATA_WIDTH, default 16, SHALL set the signed Q4.12 word width.
REQ-004 Ports SHALL be as follows:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begins a collection; samples num_rows and act_sel.
- num_rows  in  $clog2(MAX_ROWS)+1  number of rows to collect.
- act_sel  in  2  activation select: 00 identity, 01 hard sigmoid, 10 hard tanh, 11 identity.
- result_in  in  DATA_WIDTH signed  upstream matvec row result.
- result_valid  in  1  result_in is valid this cycle.
- bias_in  in  DATA_WIDTH signed  per-row bias, sampled with result_in; present only with GAB_BIAS_ADD_EN.
- out_read_en  in  1  read request.
- out_base_addr  in  $clog2(MAX_ROWS)  first row index of the read.
- out_data  out  DATA_WIDTH signed x BANDWIDTH  activated words.
- out_valid  out  1  out_data is valid.
- busy  out  1  high in COLLECT.
- done  out  1  one-cycle pulse when collection completes.
- overrun  out  1  sticky; result_valid arrived outside COLLECT.

Function
REQ-005 The FSM SHALL have three states: IDLE, COLLECT and READY.
REQ-006 Transitions: start in any state -> COLLECT with the row counter cleared; COLLECT -> READY after num_rows writes; a reset to IDLE.
REQ-007 start received while in COLLECT SHALL discard the partial collection and restart at row 0.
REQ-008 Pipeline stage 1: on each clock edge with result_valid high in COLLECT, the activated value SHALL be registered.
REQ-009 Stage 2: the next edge SHALL write the stage-1 value to buffer[row] and increment row.
REQ-010 done SHALL pulse, and the FSM SHALL enter READY, in the cycle after the last write.
REQ-011 num_rows=0 SHALL go to READY with a done pulse one cycle after start.
REQ-012 num_rows > MAX_ROWS SHALL be clamped to MAX_ROWS.
REQ-013 Hard sigmoid SHALL compute clamp((x>>>2)+2048, 0, 4096).
REQ-014 Hard tanh SHALL compute clamp(x, -4096, 4096).
REQ-015 Identity SHALL pass x unchanged.
REQ-016 All intermediate arithmetic SHALL be at least DATA_WIDTH+2 bits and saturated to the signed DATA_WIDTH range before the buffer write.
REQ-017 Reads SHALL be honoured in READY only.
- out_data[k] SHALL equal buffer[out_base_addr+k] one cycle after out_read_en, with out_valid high for that cycle.
- Indices >= collected rows SHALL return 0.
- out_read_en outside READY SHALL leave out_valid low.
REQ-018 result_valid in IDLE or READY SHALL be ignored and SHALL set overrun; overrun SHALL clear on start.
REQ-019 A result_valid and start in the same cycle SHALL honour start and discard that beat.

Reset
REQ-020 Asserting rst_n low SHALL asynchronously force:
- state IDLE;
- row counter, pipeline registers, out_data, out_valid, busy, done and overrun to 0.
REQ-021 Reset mid-COLLECT SHALL abandon the collection; buffer contents are not required to be cleared.

Configuration
REQ-022 With GAB_BIAS_ADD_EN defined, bias_in SHALL exist, and x SHALL be the saturated sum result_in+bias_in before activation.
REQ-023 Without GAB_BIAS_ADD_EN, bias_in SHALL be absent and x SHALL equal result_in.

Structure
REQ-024 Package matvec_pkg SHALL hold:
- Q_FRAC=12 and ONE_Q=4096;
- the act_sel enum;
- the FSM state enum;
- a saturate-to-DATA_WIDTH function.
REQ-025 The activation SHALL be a combinational sub-module named act_pwl, instantiated once.

Verification
REQ-026 Hard sigmoid, num_rows=4, inputs 0, 4096, 8192, -16384 -> buffer 2048, 3072, 4096, 0; done pulses 2 cycles after the 4th beat.
REQ-027 Hard tanh, num_rows=2, inputs 12288, -2048 -> read at address 0 returns 4096, -2048, 0, 0, with out_valid high for 1 cycle.
REQ-028 start after 2 of 4 beats -> busy stays high, the row counter restarts, and 4 further beats are needed for done.
REQ-029 result_valid pulse while in READY -> overrun=1 and the buffer is unchanged; the next start clears overrun.
REQ-030 GAB_BIAS_ADD_EN with identity: result 32767 + bias 4096 -> 32767; result -4096 + bias 4096 -> 0.
REQ-031 rst_n asserted mid-COLLECT -> all outputs go to 0 immediately; a subsequent read in IDLE gives out_valid=0.
